// File: rtl/sm4_axis8_unpad_pkg.sv
// Shared definitions for the SM4 8-bit AXIS unpad block.
//   state_t        : parser states (header capture, payload pass, pad drop)
//   SM4_BLK_BYTES  : SM4 block size in bytes; padded frames are a multiple of this
//   hdr_bytes_ok() : legality check for the length-field width parameter
package sm4_axis8_unpad_pkg;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam int unsigned SM4_BLK_BYTES = 16;

  function automatic bit hdr_bytes_ok(input int unsigned n);
    return (n >= 1) && (n <= 4);
  endfunction

endpackage

// File: rtl/sm4_axis8_unpad.sv
// Strips the length header and zero padding from decrypted SM4 frames.
// Each input frame: HDR_BYTES big-endian length L, payload, 0x00 pad.
// Exactly L payload bytes are forwarded, tlast on byte L (or early on a
// short frame, flagged by err_short). No backpressure in either direction.
//   clk, rst        : clock, asynchronous active-high reset
//   s_axis_*        : decrypted byte stream in (tdata, tvalid, tlast, tuser)
//   m_axis_*        : payload byte stream out, 1 clk latency, tuser carried along
//   err_short       : pulse, frame ended before L payload bytes
//   frame_done      : pulse on every input tlast
//   len_out         : L of the current frame
module sm4_axis8_unpad
  import sm4_axis8_unpad_pkg::*;
#(
  parameter int unsigned HDR_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  input  logic [7:0]             s_axis_tuser,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic [7:0]             m_axis_tuser,
  output logic                   err_short,
  output logic                   frame_done,
  output logic [HDR_BYTES*8-1:0] len_out
);

  localparam int unsigned LW = HDR_BYTES * 8;
  localparam logic [LW-1:0] ONE = LW'(1);

  if (!hdr_bytes_ok(HDR_BYTES)) begin : g_bad_hdr_bytes
    $error("sm4_axis8_unpad: HDR_BYTES must be 1..4");
  end

  state_t        state, state_nxt;
  logic [1:0]    hdr_idx, hdr_idx_nxt;
  logic [LW-1:0] len_sr, len_sr_nxt;
  logic [LW-1:0] rem, rem_nxt;
  logic [LW-1:0] len_out_nxt;
  logic [LW-1:0] field;
  logic          hdr_last;
  logic [7:0]    tdata_nxt, tuser_nxt;
  logic          tvalid_nxt, tlast_nxt, err_nxt, done_nxt;

  always_comb begin
    state_nxt   = state;
    hdr_idx_nxt = hdr_idx;
    len_sr_nxt  = len_sr;
    rem_nxt     = rem;
    len_out_nxt = len_out;
    tdata_nxt   = m_axis_tdata;
    tuser_nxt   = m_axis_tuser;
    tvalid_nxt  = 1'b0;
    tlast_nxt   = 1'b0;
    err_nxt     = 1'b0;
    done_nxt    = 1'b0;
    // Truncating the concatenation shifts the new byte in MSB-first for any width.
    field       = LW'({len_sr, s_axis_tdata});
    hdr_last    = (hdr_idx == 2'(HDR_BYTES - 1));

    if (s_axis_tvalid) begin
      unique case (state)
        ST_HDR: begin
          len_sr_nxt  = field;
          hdr_idx_nxt = hdr_idx + 2'd1;
          if (hdr_last) begin
            hdr_idx_nxt = '0;
            rem_nxt     = field;
            len_out_nxt = field;
            state_nxt   = (field != '0) ? ST_PASS : ST_DROP;
          end
          // A header-only frame that declares L=0 is complete, not short.
          if (s_axis_tlast) err_nxt = !(hdr_last && field == '0);
        end
        ST_PASS: begin
          tvalid_nxt = 1'b1;
          tdata_nxt  = s_axis_tdata;
          tuser_nxt  = s_axis_tuser;
          tlast_nxt  = (rem == ONE) || s_axis_tlast;
          rem_nxt    = (rem != '0) ? rem - ONE : '0;
          if (rem == ONE) state_nxt = ST_DROP;
          if (s_axis_tlast && rem > ONE) err_nxt = 1'b1;
        end
        ST_DROP: ;
        default: state_nxt = ST_HDR;
      endcase

      // Input tlast always realigns to a fresh header, overriding the above.
      if (s_axis_tlast) begin
        done_nxt    = 1'b1;
        hdr_idx_nxt = '0;
        state_nxt   = ST_HDR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_HDR;
      hdr_idx       <= '0;
      len_sr        <= '0;
      rem           <= '0;
      len_out       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      err_short     <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_nxt;
      hdr_idx       <= hdr_idx_nxt;
      len_sr        <= len_sr_nxt;
      rem           <= rem_nxt;
      len_out       <= len_out_nxt;
      m_axis_tdata  <= tdata_nxt;
      m_axis_tuser  <= tuser_nxt;
      m_axis_tvalid <= tvalid_nxt;
      m_axis_tlast  <= tlast_nxt;
      err_short     <= err_nxt;
      frame_done    <= done_nxt;
    end
  end

endmodule
